// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types, constants and helpers for the segment display arbiter
package seg_disp_pkg;

    localparam int NUM_REQ    = 3;
    localparam int NUM_DIGITS = 8;
    localparam int BCD_DIGITS = 10;

    localparam logic [31:0] ERR_PATTERN = 32'hEEEEEEEE;
    localparam logic [7:0]  BLANK_RST   = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD,
        HOLD
    } state_t;

    // One-hot round-robin pick; search starts just after the last granted index.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic [1:0]         last);
        logic [NUM_REQ-1:0] grant;
        logic [1:0]         idx;
        grant = '0;
        idx   = last;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
            if (grant == '0 && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic [NUM_DIGITS-1:0] leading_blank(input logic [4*NUM_DIGITS-1:0] dig);
        logic [NUM_DIGITS-1:0] b;
        logic                  zero_run;
        b        = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (dig[4*k +: 4] == 4'd0);
            b[k]     = zero_run;
        end
        return b;
    endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// rtl/bcd_serial_conv.sv - serial double-dabble binary to BCD, one input bit per cycle
module bcd_serial_conv
    import seg_disp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             data_in,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    logic [31:0]             sh_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4:0]              cnt_q;
    logic                    run_q;
    logic [3:0]              nib;

    // bcd is the post-shift value; it is the final result in the cycle done is high.
    always_comb begin
        nib    = '0;
        bcd    = '0;
        bcd[0] = sh_q[31];
        for (int k = 0; k < BCD_DIGITS; k++) begin
            nib = bcd_q[4*k +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            for (int b = 0; b < 4; b++) begin
                if (4*k + b + 1 < 4*BCD_DIGITS) begin
                    bcd[4*k + b + 1] = nib[b];
                end
            end
        end
    end

    assign done = run_q && (cnt_q == 5'd31);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            sh_q  <= data_in;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= bcd;
            sh_q  <= {sh_q[30:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner selection and formatting for the 8-digit display
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_hex,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    disp_en,
    output logic                    ovf,
    output logic [1:0]              src_id
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t                  state_q, state_d;
    logic [1:0]              rr_last_q;
    logic [1:0]              idx_q;
    logic [HW-1:0]           hold_q;

    logic [1:0]              win_idx;
    logic [31:0]             win_data;
    logic                    win_hex;
    logic                    xfer;

    logic                    conv_start;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic                    load_hex;
    logic                    load_dec;
    logic                    fmt_ovf;
    logic [31:0]             fmt_dig;

    // Only the current owner may re-grant while its hold time runs.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE) begin
            req_ready = rr_pick(req_valid, rr_last_q);
        end else if (state_q == HOLD) begin
            req_ready = req_valid & (NUM_REQ'(1) << src_id);
        end
    end

    always_comb begin
        win_idx = 2'd0;
        if (req_ready[1]) begin
            win_idx = 2'd1;
        end
        if (req_ready[2]) begin
            win_idx = 2'd2;
        end
    end

    assign win_data = req_data[32*win_idx +: 32];
    assign win_hex  = req_hex[win_idx];
    assign xfer     = |(req_valid & req_ready);

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        conv_start = 1'b0;
        load_hex   = 1'b0;
        load_dec   = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && hold_q <= HW'(1)) begin
                    state_d = IDLE;
                end
                if (xfer) begin
                    if (win_hex) begin
                        state_d  = LOAD;
                        load_hex = 1'b1;
                    end else begin
                        state_d    = CONV;
                        conv_start = 1'b1;
                    end
                end
            end
            CONV: begin
                busy = 1'b1;
                if (conv_done) begin
                    state_d  = LOAD;
                    load_dec = 1'b1;
                end
            end
            LOAD:    state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    bcd_serial_conv u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (conv_start),
        .data_in (win_data),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    assign fmt_ovf = |conv_bcd[4*BCD_DIGITS-1:32];
    assign fmt_dig = fmt_ovf ? ERR_PATTERN : conv_bcd[31:0];

    // Display registers are written on the edge into LOAD so all fields change together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q <= 2'd2;
            idx_q     <= 2'd0;
            hold_q    <= '0;
            digits    <= '0;
            blank     <= BLANK_RST;
            disp_en   <= 1'b0;
            ovf       <= 1'b0;
            src_id    <= 2'd0;
        end else begin
            if (xfer) begin
                rr_last_q <= win_idx;
                idx_q     <= win_idx;
            end
            if (state_q == LOAD) begin
                hold_q <= HW'(HOLD_CYCLES);
            end else if (state_q == HOLD && hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end
            if (load_hex) begin
                digits  <= win_data;
                blank   <= leading_blank(win_data);
                ovf     <= 1'b0;
                src_id  <= win_idx;
                disp_en <= 1'b1;
            end else if (load_dec) begin
                digits  <= fmt_dig;
                blank   <= leading_blank(fmt_dig);
                ovf     <= fmt_ovf;
                src_id  <= idx_q;
                disp_en <= 1'b1;
            end
        end
    end

endmodule
